unload_numbers: RTL and testbench
=================================

// Module: unload_numbers
// PURPOSE
//  Parallel-to-serial reader for the RSA operand store. Takes three 1024-bit operands in one
//  load: modulus n, private key d and ciphertext c. Streams them out as 32 lock-stepped 32-bit
//  word triples over a valid/ready handshake, most-significant word first.
//  Emission order matches the word-accumulating store, so feeding the stream back into the
//  store reproduces the original operands. Sits between key/cipher storage and the narrow
//  datapath or host link.
// PARAMETERS
//  WORD_W     32    width of each emitted word
//  NUM_WORDS  32    words per operand; operand width OP_W = WORD_W*NUM_WORDS (1024)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  load       in   1       capture request for n_in/d_in/c_in; honoured only when busy==0
//  n_in       in   OP_W    product of primes
//  d_in       in   OP_W    private key
//  c_in       in   OP_W    cipher text
//  busy       out  1       1 from the cycle after an accepted load until the last word handshakes
//  out_valid  out  1       current word triple valid
//  out_ready  in   1       consumer accepts the word triple when out_valid & out_ready
//  n_out      out  WORD_W  current word of n
//  d_out      out  WORD_W  current word of d
//  c_out      out  WORD_W  current word of c
//  word_idx   out  clog2(NUM_WORDS)  index of current word, 0 = most-significant
//  out_last   out  1       high with out_valid when word_idx==NUM_WORDS-1
// BEHAVIOUR
//  Reset (async assert, sync deassert by clk edge):
//   - State IDLE; all shift regs, word_idx, outputs = 0.
//   - Reset mid-stream abandons the transfer; no partial words after release.
//  FSM: IDLE, SEND.
//   - IDLE: busy=0, out_valid=0.
//   - IDLE, load=1 -> capture n_in/d_in/c_in into three OP_W shift regs, word_idx=0, go SEND.
//     out_valid=1 on the next cycle, so load-to-first-word latency is 1 clk.
//   - SEND: out_valid=1, busy=1.
//     Word outputs are always the top WORD_W bits of each shift reg: n_out = n_sr[OP_W-1 -: WORD_W].
//   - SEND, handshake, word_idx<NUM_WORDS-1 -> shift all three regs left by WORD_W (zero fill),
//     word_idx+1, stay in SEND.
//   - SEND, handshake, word_idx==NUM_WORDS-1 -> go IDLE, out_valid=0 and busy=0 next cycle.
//     Shift regs are not cleared.
//   - SEND, out_ready=0 -> all outputs held bit-stable; valid is never withdrawn without a handshake.
//  Boundary rules:
//   - load while busy (including the final-handshake cycle) is ignored. Inputs are not sampled
//     and no error is flagged. Back-to-back transfers therefore have >=1 idle cycle between them.
//   - out_ready high in IDLE has no effect.
//   - word_idx never wraps in SEND; the FSM exits on the last word.
//   - Max throughput is 1 word triple per clk. A full transfer is NUM_WORDS handshakes.
//   - n/d/c always advance together; there is no per-operand skew.
// STRUCTURE
//  Shared package/header rsa_defs:
//   - WORD_W, NUM_WORDS, OP_W and IDX_W = clog2(NUM_WORDS).
//   - State encoding localparams IDLE=1'b0, SEND=1'b1.
//   - Shared with the storing block.
//  Sub-module word_shift_reg (params WORD_W, NUM_WORDS):
//   - Ports clk, rst, load, shift, din[OP_W], dout_word[WORD_W].
//   - Instantiated three times (n, d, c).
//  Top level holds the FSM, word_idx counter and handshake logic only.
// TESTING
//  1. Reset: assert rst mid-cycle with no clk edge -> busy, out_valid, outputs all 0 immediately.
//  2. Load n_in = {32 words 0x0000_001F..0x0000_0000 descending} with out_ready=1 ->
//     n_out = 0x1F,0x1E,...,0x00 on 32 consecutive cycles; out_last only on the 32nd; busy
//     drops the cycle after.
//  3. Backpressure: out_ready toggles 1,0,0,1,... -> each word held stable while stalled.
//     No word dropped or duplicated; the 32 handshakes match the 32 expected words.
//  4. Ignored load: pulse load with d_in=all-ones at word_idx=10 -> stream continues with the
//     original d words; no effect on busy.
//  5. Reset mid-stream at word_idx=5 -> out_valid=0 at once. A new load after release starts
//     at word_idx=0 with the new data.
//  6. Round trip: random n/d/c -> stream into the word-accumulating store ->
//     stored primeNum/privateKey/cipher equal n_in/d_in/c_in bit-exact.

Source files
------------

// File: rtl/unload_numbers_pkg.sv
// Shared RSA operand-store definitions: word geometry and the reader/store FSM encoding.
package unload_numbers_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 32;
   localparam int OP_W      = WORD_W * NUM_WORDS;
   localparam int IDX_W     = $clog2(NUM_WORDS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/unload_numbers_word_shift_reg.sv
// One operand register: parallel capture, then shifts left one word at a time so the
// most-significant word is always presented on dout_word.
module word_shift_reg #(
   parameter int  WORD_W    = unload_numbers_pkg::WORD_W,
   parameter int  NUM_WORDS = unload_numbers_pkg::NUM_WORDS,
   localparam int OP_W      = WORD_W * NUM_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [OP_W-1:0]   din,
   output logic [WORD_W-1:0] dout_word
);
   import unload_numbers_pkg::*;

   logic [OP_W-1:0] sr_r;

   // Operand storage: load wins over shift; contents are kept after the last word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_r <= {OP_W{1'b0}};
      end else if (load) begin
         sr_r <= din;
      end else if (shift) begin
         sr_r <= {sr_r[OP_W-WORD_W-1:0], {WORD_W{1'b0}}};
      end else begin
         sr_r <= sr_r;
      end
   end

   assign dout_word = sr_r[OP_W-1 -: WORD_W];

endmodule

// File: rtl/unload_numbers.sv
// Parallel-to-serial reader for the RSA operand store: streams n/d/c as lock-stepped word
// triples, most-significant word first, over a valid/ready handshake.
module unload_numbers #(
   parameter int  WORD_W    = unload_numbers_pkg::WORD_W,
   parameter int  NUM_WORDS = unload_numbers_pkg::NUM_WORDS,
   localparam int OP_W      = WORD_W * NUM_WORDS,
   localparam int IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [OP_W-1:0]   n_in,
   input  logic [OP_W-1:0]   d_in,
   input  logic [OP_W-1:0]   c_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] n_out,
   output logic [WORD_W-1:0] d_out,
   output logic [WORD_W-1:0] c_out,
   output logic [IDX_W-1:0]  word_idx,
   output logic              out_last
);
   import unload_numbers_pkg::*;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t           state_r;
   state_t           state_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_s;
   logic             load_s;
   logic             shift_s;

   // FSM state and word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         idx_r   <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
      end
   end

   // Next-state: loads are only seen in IDLE, so a load during the final handshake is dropped.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (load) begin
               load_s  = 1'b1;
               idx_s   = {IDX_W{1'b0}};
               state_s = SEND;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx_r == LAST_IDX) begin
                  state_s = IDLE;
               end else begin
                  shift_s = 1'b1;
                  idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign busy      = (state_r == SEND);
   assign out_valid = (state_r == SEND);
   assign out_last  = (state_r == SEND) && (idx_r == LAST_IDX);
   assign word_idx  = idx_r;

   word_shift_reg #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_n_sr (
      .clk(clk), .rst(rst), .load(load_s), .shift(shift_s), .din(n_in), .dout_word(n_out)
   );

   word_shift_reg #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_d_sr (
      .clk(clk), .rst(rst), .load(load_s), .shift(shift_s), .din(d_in), .dout_word(d_out)
   );

   word_shift_reg #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_c_sr (
      .clk(clk), .rst(rst), .load(load_s), .shift(shift_s), .din(c_in), .dout_word(c_out)
   );

endmodule

// File: tb/tb_unload_numbers.sv
// Scoreboard bench for unload_numbers: expected word triples are queued at load time and
// checked on every handshake; a word-accumulating store model checks the round trip.
module tb_unload_numbers;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 32;
   localparam int OP_W      = WORD_W * NUM_WORDS;
   localparam int IDX_W     = 5;

   typedef struct packed {
      logic [WORD_W-1:0] n;
      logic [WORD_W-1:0] d;
      logic [WORD_W-1:0] c;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic [OP_W-1:0]   n_in, d_in, c_in;
   logic              busy, out_valid, out_ready, out_last;
   logic [WORD_W-1:0] n_out, d_out, c_out;
   logic [IDX_W-1:0]  word_idx;

   exp_t              sb_q[$];
   logic [OP_W-1:0]   acc_n, acc_d, acc_c;
   logic [OP_W-1:0]   cur_n, cur_d, cur_c;
   int                n_vec = 0;
   int                n_err = 0;

   unload_numbers dut (
      .clk(clk), .rst(rst), .load(load),
      .n_in(n_in), .d_in(d_in), .c_in(c_in),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .n_out(n_out), .d_out(d_out), .c_out(c_out),
      .word_idx(word_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [OP_W-1:0] rand_op();
      logic [OP_W-1:0] r;
      for (int i = 0; i < NUM_WORDS; i++) r[WORD_W*i +: WORD_W] = $urandom();
      return r;
   endfunction

   task automatic push_transfer(input logic [OP_W-1:0] n, input logic [OP_W-1:0] d,
                                input logic [OP_W-1:0] c);
      for (int i = 0; i < NUM_WORDS; i++) begin
         exp_t e;
         e.n    = n[OP_W-1-WORD_W*i -: WORD_W];
         e.d    = d[OP_W-1-WORD_W*i -: WORD_W];
         e.c    = c[OP_W-1-WORD_W*i -: WORD_W];
         e.idx  = IDX_W'(i);
         e.last = (i == NUM_WORDS - 1);
         sb_q.push_back(e);
      end
      cur_n = n; cur_d = d; cur_c = c;
      acc_n = '0; acc_d = '0; acc_c = '0;
   endtask

   task automatic start_load(input logic [OP_W-1:0] n, input logic [OP_W-1:0] d,
                             input logic [OP_W-1:0] c);
      @(negedge clk);
      n_in = n; d_in = d; c_in = c;
      load = 1'b1;
      push_transfer(n, d, c);
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random. ign_idx: pulse load there (-1 none).
   // final_load: raise load during the last handshake and leave it high.
   task automatic drain(input int mode, input int ign_idx, input bit final_load);
      logic [103:0] held;
      logic [103:0] now_v;
      bit           stalled = 1'b0;
      bit           ign_done = 1'b0;
      bit           ready_v;
      int           cyc = 0;
      exp_t         e;
      while (sb_q.size() > 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (ign_done) load = 1'b0;
         now_v = {busy, out_valid, out_last, word_idx, n_out, d_out, c_out};
         if (stalled) begin
            n_vec++;
            if (now_v !== held) begin
               n_err++;
               $display("FAIL stall_hold: got %h, required %h", now_v, held);
            end
         end
         n_vec++;
         if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL valid_busy: got valid=%b busy=%b, required 1/1", out_valid, busy);
         end
         case (mode)
            0:       ready_v = 1'b1;
            1:       ready_v = (cyc % 3 == 1);
            default: ready_v = 1'($urandom_range(0, 1));
         endcase
         if (ready_v && out_valid === 1'b1) begin
            e = sb_q.pop_front();
            n_vec++;
            if ({n_out, d_out, c_out, word_idx, out_last} !== e) begin
               n_err++;
               $display("FAIL word: got n=%h d=%h c=%h idx=%0d last=%b, required n=%h d=%h c=%h idx=%0d last=%b",
                        n_out, d_out, c_out, word_idx, out_last, e.n, e.d, e.c, e.idx, e.last);
            end
            acc_n = {acc_n[OP_W-WORD_W-1:0], n_out};
            acc_d = {acc_d[OP_W-WORD_W-1:0], d_out};
            acc_c = {acc_c[OP_W-WORD_W-1:0], c_out};
            if (final_load && sb_q.size() == 0) load = 1'b1;
         end
         stalled = out_valid && !ready_v;
         held    = now_v;
         if (ign_idx >= 0 && !ign_done && out_valid && word_idx == IDX_W'(ign_idx)) begin
            d_in = {OP_W{1'b1}};
            n_in = {OP_W{1'b1}};
            load = 1'b1;
            ign_done = 1'b1;
         end
         out_ready = ready_v;
      end
      if (sb_q.size() > 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d words left, required 0", sb_q.size());
         sb_q.delete();
      end
      if (!final_load) load = 1'b0;
   endtask

   task automatic check_round_trip(input string name);
      n_vec++;
      if (acc_n !== cur_n || acc_d !== cur_d || acc_c !== cur_c) begin
         n_err++;
         $display("FAIL %s: got n=%h.. required n=%h..", name, acc_n[OP_W-1 -: 64], cur_n[OP_W-1 -: 64]);
      end
   endtask

   task automatic check_idle(input string name);
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL %s: got busy=%b valid=%b last=%b, required 0/0/0", name, busy, out_valid, out_last);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_vec++;
      if ({busy, out_valid, out_last, word_idx, n_out, d_out, c_out} !== 104'd0) begin
         n_err++;
         $display("FAIL %s: got busy=%b valid=%b idx=%0d n=%h d=%h c=%h, required all 0",
                  name, busy, out_valid, word_idx, n_out, d_out, c_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; out_ready = 1'b0;
      n_in = '0; d_in = '0; c_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_state");
      start_load(rand_op(), rand_op(), rand_op());
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || word_idx !== 5'd0) begin
         n_err++;
         $display("FAIL load_latency: got valid=%b idx=%0d, required 1/0", out_valid, word_idx);
      end
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_descending();
      logic [OP_W-1:0] n_v;
      for (int i = 0; i < NUM_WORDS; i++) n_v[OP_W-1-WORD_W*i -: WORD_W] = 32'(31 - i);
      out_ready = 1'b1;
      start_load(n_v, rand_op(), rand_op());
      drain(0, -1, 1'b0);
      @(negedge clk);
      check_idle("busy_drop");
      repeat (3) @(negedge clk);
      check_idle("ready_in_idle");
      check_round_trip("descending_rt");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      start_load(rand_op(), rand_op(), rand_op());
      drain(1, -1, 1'b0);
      check_round_trip("backpressure_rt");
   endtask

   task automatic test_ignored_load();
      out_ready = 1'b1;
      start_load(rand_op(), rand_op(), rand_op());
      drain(0, 10, 1'b0);
      check_round_trip("ignored_load_rt");
   endtask

   task automatic test_reset_mid_stream();
      int guard = 0;
      out_ready = 1'b1;
      start_load(rand_op(), rand_op(), rand_op());
      do begin
         @(negedge clk);
         guard++;
      end while (!(out_valid === 1'b1 && word_idx == 5'd5) && guard < 60);
      n_vec++;
      if (guard >= 60) begin
         n_err++;
         $display("FAIL reach_idx5: got idx=%0d, required 5", word_idx);
      end
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1 check_all_zero("mid_reset");
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("after_release");
      start_load(rand_op(), rand_op(), rand_op());
      drain(2, -1, 1'b0);
      check_round_trip("reload_rt");
   endtask

   task automatic test_back_to_back();
      logic [OP_W-1:0] bn, bd, bc;
      out_ready = 1'b1;
      start_load(rand_op(), rand_op(), rand_op());
      bn = rand_op(); bd = rand_op(); bc = rand_op();
      n_in = bn; d_in = bd; c_in = bc;
      drain(0, -1, 1'b1);
      check_round_trip("b2b_first_rt");
      @(negedge clk);
      check_idle("final_hs_load_ignored");
      push_transfer(bn, bd, bc);
      @(posedge clk);
      #1 load = 1'b0;
      drain(2, -1, 1'b0);
      check_round_trip("b2b_second_rt");
   endtask

   initial begin
      test_reset();
      test_descending();
      test_backpressure();
      test_ignored_load();
      test_reset_mid_stream();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
